mcht_tx_sched: RTL and testbench

- Round-robin transmit scheduler that shares one Manchester transceiver TX path (TX_VLD/TX_MSG/TX_DNE handshake) between pNUM_REQ requesters.
- Grants one requester at a time and latches its message.
- Issues a single-cycle TX_VLD, waits for TX_DNE or a timeout, and enforces an inter-frame gap.
- Sits between the user-side message sources and MCHT_TRX; clocked from the same 25 MHz domain as the TRX.

---
 rtl/mcht_tx_sched.sv | 124 ++++++++++++
 tb/tb_mcht_tx_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcht_tx_sched.sv
// Round-robin transmit scheduler: shares one Manchester TRX transmit path
// (TX_VLD / TX_MSG / TX_DNE) between pNUM_REQ requesters, with timeout
// abort, inter-frame gap and saturating frame/error counters.
module mcht_tx_sched #(
  parameter int unsigned pNUM_REQ = 4,
  parameter int unsigned pMSG_LEN = 8,
  parameter int unsigned pTMO     = 1024,
  parameter int unsigned pGAP     = 4
) (
  input  logic                         CLK_25M,
  input  logic                         RST,
  input  logic                         HALT,
  input  logic [pNUM_REQ-1:0]          REQ,
  input  logic [pNUM_REQ*pMSG_LEN-1:0] REQ_MSG,
  output logic [pNUM_REQ-1:0]          GNT,
  output logic [pNUM_REQ-1:0]          DNE,
  output logic [pNUM_REQ-1:0]          ERR,
  output logic                         TX_VLD,
  output logic [pMSG_LEN-1:0]          TX_MSG,
  input  logic                         TX_DNE,
  output logic                         BUSY,
  output logic [7:0]                   FRM_CNT,
  output logic [7:0]                   ERR_CNT
);

  localparam int unsigned LW = $clog2(pNUM_REQ);
  localparam int unsigned TW = $clog2(pTMO);
  localparam int unsigned GW = (pGAP > 1) ? $clog2(pGAP) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StGap} state_t;

  state_t         r_state;
  logic [LW-1:0]  r_last;
  logic [LW-1:0]  r_widx;
  logic [TW-1:0]  r_tmo;
  logic [GW-1:0]  r_gap;

  logic           w_any;
  logic [LW-1:0]  w_win;
  logic [LW-1:0]  w_idx;

  // Winner search: first asserted REQ going upward from last+1, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= pNUM_REQ; k++) begin
      w_idx = LW'((32'(r_last) + k) % pNUM_REQ);
      if (!w_any && REQ[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      r_state <= StIdle;
      r_last  <= LW'(pNUM_REQ - 1);
      r_widx  <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      GNT     <= '0;
      DNE     <= '0;
      ERR     <= '0;
      TX_VLD  <= 1'b0;
      TX_MSG  <= '0;
      BUSY    <= 1'b0;
      FRM_CNT <= '0;
      ERR_CNT <= '0;
    end else begin
      // Strobes default low; each is raised for one cycle only.
      TX_VLD <= 1'b0;
      DNE    <= '0;
      ERR    <= '0;
      case (r_state)
        StIdle: begin
          if (!HALT && w_any) begin
            GNT     <= pNUM_REQ'(1) << w_win;
            TX_MSG  <= REQ_MSG[w_win*pMSG_LEN +: pMSG_LEN];
            r_widx  <= w_win;
            TX_VLD  <= 1'b1;
            BUSY    <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_tmo   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          r_tmo <= r_tmo + 1'b1;
          // TX_DNE takes precedence over a coincident timeout.
          if (TX_DNE) begin
            DNE     <= GNT;
            GNT     <= '0;
            r_last  <= r_widx;
            r_gap   <= '0;
            r_state <= StGap;
            if (FRM_CNT != 8'hFF) FRM_CNT <= FRM_CNT + 8'd1;
          end else if (r_tmo == TW'(pTMO - 1)) begin
            ERR     <= GNT;
            GNT     <= '0;
            r_last  <= r_widx;
            r_gap   <= '0;
            r_state <= StGap;
            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
          end
        end
        StGap: begin
          if (r_gap == GW'(pGAP - 1)) begin
            BUSY    <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mcht_tx_sched.sv
// Self-checking bench for mcht_tx_sched: directed scenarios plus randomized
// frames, checked against a transaction-level round-robin model.
module tb_mcht_tx_sched;

  localparam int N   = 4;
  localparam int M   = 8;
  localparam int TMO = 16;
  localparam int GAP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           halt;
  logic [N-1:0]   req;
  logic [N*M-1:0] req_msg;
  logic           tx_dne;
  logic [N-1:0]   gnt, dne, err;
  logic           tx_vld;
  logic [M-1:0]   tx_msg;
  logic           busy;
  logic [7:0]     frm_cnt, err_cnt;

  mcht_tx_sched #(
    .pNUM_REQ(N),
    .pMSG_LEN(M),
    .pTMO    (TMO),
    .pGAP    (GAP)
  ) dut (
    .CLK_25M(clk),
    .RST    (rst),
    .HALT   (halt),
    .REQ    (req),
    .REQ_MSG(req_msg),
    .GNT    (gnt),
    .DNE    (dne),
    .ERR    (err),
    .TX_VLD (tx_vld),
    .TX_MSG (tx_msg),
    .TX_DNE (tx_dne),
    .BUSY   (busy),
    .FRM_CNT(frm_cnt),
    .ERR_CNT(err_cnt)
  );

  always #20 clk = ~clk;

  // Reference model state
  int m_last = N - 1;
  int m_frm  = 0;
  int m_err  = 0;
  int n_cmp  = 0;
  int n_mis  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (lst + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; halt = 1'b0; tx_dne = 1'b0;
    tick();
    rst = 1'b0;
    m_last = N - 1; m_frm = 0; m_err = 0;
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_dne_err", 32'({dne, err}), 0);
    check_eq("rst_vld_busy", 32'({tx_vld, busy}), 0);
    check_eq("rst_msg", 32'(tx_msg), 0);
    check_eq("rst_cnts", 32'({frm_cnt, err_cnt}), 0);
  endtask

  // Cycles in IDLE where no grant may happen (HALT or no request).
  task automatic idle_chk(input int cycles, input logic [N-1:0] r);
    req  = r;
    halt = (r != '0) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int i = 0; i < cycles; i++) begin
      tx_dne = 1'($urandom_range(0, 1));
      tick();
      check_eq("idle_gnt", 32'({gnt, dne, err}), 0);
      check_eq("idle_busy", 32'({tx_vld, busy}), 0);
      check_eq("idle_frm", 32'(frm_cnt), 32'(m_frm));
      check_eq("idle_err", 32'(err_cnt), 32'(m_err));
    end
    tx_dne = 1'b0;
  endtask

  // One full transaction. j = cycle in WAIT at which TX_DNE is sampled;
  // j > TMO means TX_DNE never arrives and the timeout fires.
  task automatic frame(input logic [N-1:0] r, input logic [N*M-1:0] msgs, input int j,
                       input bit halt_mid, input bit drop, input bit stray, output int w_out);
    int w;
    int last_c;
    logic [M-1:0] m;
    logic [N-1:0] oh;
    bit ok;
    req = r; req_msg = msgs; halt = 1'b0; tx_dne = stray;
    w  = rr_pick(r, m_last);
    m  = msgs[w*M +: M];
    oh = N'(1) << w;
    tick();
    check_eq("grant_gnt", 32'(gnt), 32'(oh));
    check_eq("grant_msg", 32'(tx_msg), 32'(m));
    check_eq("grant_vld", 32'({tx_vld, busy}), 32'b11);
    check_eq("grant_cnt", 32'(frm_cnt), 32'(m_frm));
    // LOAD cycle: perturb inputs that must no longer matter.
    if (drop) req = '0;
    req_msg = {$urandom(), $urandom()};
    halt    = halt_mid;
    tx_dne  = stray;
    tick();
    check_eq("wait_vld", 32'(tx_vld), 0);
    check_eq("wait_gnt", 32'(gnt), 32'(oh));
    tx_dne = 1'b0;
    last_c = (j <= TMO) ? j : TMO;
    for (int c = 1; c <= last_c; c++) begin
      tx_dne = (c == j);
      tick();
      if (c < last_c) check_eq("wait_quiet", 32'({dne, err, gnt}), 32'({4'b0, 4'b0, oh}));
    end
    tx_dne = 1'b0;
    ok = (j <= TMO);
    if (ok) begin
      if (m_frm < 255) m_frm++;
    end else begin
      if (m_err < 255) m_err++;
    end
    m_last = w;
    check_eq("end_dne", 32'(dne), ok ? 32'(oh) : 0);
    check_eq("end_err", 32'(err), ok ? 0 : 32'(oh));
    check_eq("end_gnt", 32'(gnt), 0);
    check_eq("end_frm", 32'(frm_cnt), 32'(m_frm));
    check_eq("end_errcnt", 32'(err_cnt), 32'(m_err));
    check_eq("end_busy", 32'(busy), 1);
    for (int g = 1; g <= GAP; g++) begin
      tx_dne = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      check_eq("gap_quiet", 32'({dne, err, gnt, tx_vld}), 0);
      check_eq("gap_msg", 32'(tx_msg), 32'(m));
      check_eq("gap_busy", 32'(busy), (g < GAP) ? 1 : 0);
      check_eq("gap_cnts", 32'({frm_cnt, err_cnt}), 32'({8'(m_frm), 8'(m_err)}));
    end
    tx_dne = 1'b0;
    w_out = w;
  endtask

  initial begin
    int w;
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;
    logic [N*M-1:0] msgs;
    int j;
    bit hm;

    rst = 1'b1; halt = 1'b0; req = '0; req_msg = '0; tx_dne = 1'b0;
    tick();
    do_reset();

    // HALT blocks grants
    idle_chk(5, 4'b0001);

    // Single request
    msgs = {$urandom()};
    msgs[15:8] = 8'hA5;
    frame(4'b0010, msgs, 10, 1'b0, 1'b0, 1'b0, w);
    check_eq("single_w", 32'(w), 1);
    check_eq("single_frm", 32'(frm_cnt), 1);

    // Round-robin with all requests held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      frame(4'b1111, 32'h43322110, 3, 1'b0, 1'b0, 1'b0, w);
      check_eq("rr_order", 32'(w), 32'(rr_exp[i]));
    end

    // Timeout, then next requester served normally
    frame(4'b0011, {$urandom()}, TMO + 5, 1'b0, 1'b0, 1'b0, w);
    check_eq("tmo_w", 32'(w), 1);
    frame(4'b0011, {$urandom()}, 5, 1'b0, 1'b0, 1'b0, w);
    check_eq("tmo_next_w", 32'(w), 0);

    // TX_DNE coincident with the last timeout cycle
    frame(4'b0100, {$urandom()}, TMO, 1'b0, 1'b0, 1'b1, w);

    // HALT raised mid-frame: frame completes, then no new grant
    frame(4'b0001, {$urandom()}, 7, 1'b1, 1'b0, 1'b0, w);
    idle_chk(6, 4'b0001);

    // Reset during WAIT
    req = 4'b0100; halt = 1'b0; req_msg = {$urandom()};
    tick(); tick(); tick();
    do_reset();
    idle_chk(4, 4'b0000);
    frame(4'b1001, {$urandom()}, 4, 1'b0, 1'b0, 1'b0, w);
    check_eq("rst_first_w", 32'(w), 0);

    // Randomized frames; enough of each outcome to saturate both counters
    for (int i = 0; i < 700; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      msgs = {$urandom()};
      if ($urandom_range(0, 1) == 1) j = $urandom_range(TMO + 1, TMO + 3);
      else j = $urandom_range(1, TMO);
      hm = 1'($urandom_range(0, 7) == 0);
      frame(r, msgs, j, hm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      if (hm) idle_chk(2, r);
    end
    if (m_frm == 255) check_eq("frm_sat", 32'(frm_cnt), 255);
    if (m_err == 255) check_eq("err_sat", 32'(err_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
